// File: rtl/imem_boot_loader.sv
// imem_boot_loader: streams a program image into instruction memory over a
// valid/ready stream, then holds the core in reset RESET_HOLD more cycles
// before releasing it.
// Optional feature macro: BOOT_CHECKSUM_EN. When it is defined, one trailer
// word follows the image and must equal the mod-2^DATA_WIDTH sum of the image.
// A mismatch parks the loader in ERROR with the core held.
module imem_boot_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int RESET_HOLD = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   word_count,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [DATA_WIDTH-1:0] imem_wdata,
  output logic                  cpu_reset,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_RUN   = 3'd4;
`ifdef BOOT_CHECKSUM_EN
  localparam logic [2:0] S_CHECK = 3'd2;
  localparam logic [2:0] S_ERROR = 3'd5;
`endif

  // Down-counter loaded with RESET_HOLD-1 so HOLD lasts exactly RESET_HOLD cycles.
  localparam int                    HOLD_W    = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
  localparam logic [HOLD_W-1:0]     HOLD_INIT = HOLD_W'(RESET_HOLD - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH     = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [2:0]            r_state;
  logic [HOLD_W-1:0]     r_hold;
  logic [ADDR_WIDTH:0]   r_count;
  logic [ADDR_WIDTH:0]   r_target;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;

  logic                  w_start_ok;
  logic                  w_load_beat;
  logic                  w_last_beat;
  logic [ADDR_WIDTH:0]   w_count_inc;
  logic [ADDR_WIDTH:0]   w_target;
  logic [2:0]            w_start_state;

  assign w_count_inc   = r_count + 1'b1;
  assign w_last_beat   = (w_count_inc == r_target);
  assign w_load_beat   = in_valid & (r_state == S_LOAD);
  // Oversized requests are clamped to the memory depth so the address never wraps.
  assign w_target      = (word_count > DEPTH) ? DEPTH : word_count;
  // An empty image skips straight to the reset-hold phase.
  assign w_start_state = (word_count == '0) ? S_HOLD : S_LOAD;

  // Output decode and start acceptance, all derived from the registered state.
  always_comb begin
    w_start_ok = start & ((r_state == S_IDLE) | (r_state == S_RUN));
    in_ready   = (r_state == S_LOAD);
    busy       = (r_state == S_LOAD) | (r_state == S_HOLD);
    error      = 1'b0;
`ifdef BOOT_CHECKSUM_EN
    w_start_ok = start & ((r_state == S_IDLE) | (r_state == S_RUN) | (r_state == S_ERROR));
    in_ready   = (r_state == S_LOAD) | (r_state == S_CHECK);
    busy       = (r_state == S_LOAD) | (r_state == S_CHECK) | (r_state == S_HOLD);
    error      = (r_state == S_ERROR);
`endif
    cpu_reset  = (r_state != S_RUN);
    done       = (r_state == S_RUN);
  end

  assign imem_we    = r_we;
  assign imem_addr  = r_addr;
  assign imem_wdata = r_wdata;

  // Write port and word counter: one registered write per accepted image word.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_count  <= '0;
      r_target <= '0;
    end else begin
      r_we <= w_load_beat;
      if (w_start_ok) begin
        r_count  <= '0;
        r_target <= w_target;
      end else if (w_load_beat) begin
        r_addr  <= r_count[ADDR_WIDTH-1:0];
        r_wdata <= in_data;
        r_count <= w_count_inc;
      end
    end
  end

`ifdef BOOT_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] r_sum;

  // Running sum of image words; the trailer is compared against it in CHECK.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sum <= '0;
    end else if (w_start_ok) begin
      r_sum <= '0;
    end else if (w_load_beat) begin
      r_sum <= r_sum + in_data;
    end
  end
`endif

  // Load sequencing: IDLE/RUN/ERROR accept start, LOAD counts beats, HOLD times the release.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_hold  <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_RUN: begin
          if (w_start_ok) begin
            r_state <= w_start_state;
            r_hold  <= HOLD_INIT;
          end
        end
        S_LOAD: begin
          if (w_load_beat && w_last_beat) begin
`ifdef BOOT_CHECKSUM_EN
            r_state <= S_CHECK;
`else
            r_state <= S_HOLD;
`endif
            r_hold  <= HOLD_INIT;
          end
        end
`ifdef BOOT_CHECKSUM_EN
        S_CHECK: begin
          if (in_valid) begin
            r_state <= (in_data == r_sum) ? S_HOLD : S_ERROR;
            r_hold  <= HOLD_INIT;
          end
        end
        S_ERROR: begin
          if (w_start_ok) begin
            r_state <= w_start_state;
            r_hold  <= HOLD_INIT;
          end
        end
`endif
        S_HOLD: begin
          if (r_hold == '0) begin
            r_state <= S_RUN;
          end else begin
            r_hold <= r_hold - 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader. Expected writes go into a scoreboard
// queue when a beat is driven; a negedge monitor pops and compares on each
// imem_we pulse. Checksum scenarios are built when BOOT_CHECKSUM_EN is defined.
module tb_imem_boot_loader;

  localparam int AW = 10;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW:0]   word_count;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [DW-1:0] imem_wdata;
  logic          cpu_reset;
  logic          busy;
  logic          done;
  logic          error;

  imem_boot_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESET_HOLD(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .word_count (word_count),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_reset  (cpu_reset),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int wr_count = 0;
  logic [AW+DW-1:0] sb_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Monitor: every write pulse must match the oldest outstanding expected write.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wr_count++;
      if (sb_q.size() == 0) begin
        chk("spurious_write_addr", 64'(imem_addr), 64'h1_0000_0000);
      end else begin
        logic [AW+DW-1:0] e;
        e = sb_q.pop_front();
        chk("write", 64'({imem_addr, imem_wdata}), 64'(e));
        $display("write addr=%03h data=%08h", imem_addr, imem_wdata);
      end
    end
  end

  // One stream beat; expect_write=0 for words that must not reach memory.
  task automatic beat(input logic [DW-1:0] d, input logic [AW-1:0] a, input bit expect_write);
    if (expect_write) sb_q.push_back({a, d});
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_start(input logic [AW:0] wc);
    word_count = wc;
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
  endtask

  // Counts cycles until done rises, bounded so a stuck DUT still reaches the summary.
  task automatic wait_done(input string tag, input int exp_cycles);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 64'(n), 64'(exp_cycles));
    $display("%s: done after %0d cycles", tag, n);
  endtask

  initial begin
    int w0;
    reset = 1'b1; start = 1'b0; word_count = '0; in_valid = 1'b0; in_data = '0;
    idle(3);
    chk("reset_flags", 64'({cpu_reset, in_ready, busy, done, error, imem_we}), 64'b100000);
    chk("reset_addr_data", 64'({imem_addr, imem_wdata}), 64'h0);
    reset = 1'b0;
    idle(1);

    // Three contiguous beats.
    w0 = wr_count;
    do_start(3);
    chk("t1_load_flags", 64'({in_ready, busy, cpu_reset}), 64'b111);
    beat(32'h11, 10'd0, 1'b1);
    beat(32'h22, 10'd1, 1'b1);
    beat(32'h33, 10'd2, 1'b1);
    chk("t1_hold_flags", 64'({in_ready, busy, cpu_reset, done}), 64'b0110);
    wait_done("t1_release", 4);
    chk("t1_cpu_reset", 64'(cpu_reset), 64'(0));
    chk("t1_writes", 64'(wr_count - w0), 64'(3));

    // Same image with two-cycle bubbles, restarted from RUN.
    w0 = wr_count;
    do_start(3);
    chk("t2_reheld", 64'({cpu_reset, done}), 64'b10);
    beat(32'h11, 10'd0, 1'b1); idle(2);
    beat(32'h22, 10'd1, 1'b1); idle(2);
    beat(32'h33, 10'd2, 1'b1);
    wait_done("t2_release", 4);
    chk("t2_writes", 64'(wr_count - w0), 64'(3));

    // Empty image from IDLE.
    reset = 1'b1; idle(1); reset = 1'b0;
    w0 = wr_count;
    do_start(0);
    chk("t3_hold_flags", 64'({in_ready, busy, cpu_reset}), 64'b011);
    wait_done("t3_release", 4);
    chk("t3_writes", 64'(wr_count - w0), 64'(0));

    // Full-depth image, then an oversized count that must saturate.
    for (int pass = 0; pass < 2; pass++) begin
      w0 = wr_count;
      do_start(pass == 0 ? 11'd1024 : 11'd1500);
      for (int i = 0; i < 1024; i++) beat(32'hA500_0000 | i | (pass << 16), i[AW-1:0], 1'b1);
      in_valid = 1'b1;
      in_data  = 32'hDEAD_BEEF;
      chk(pass == 0 ? "t4_no_ready_after_last" : "t4s_no_ready_after_last", 64'(in_ready), 64'(0));
      wait_done(pass == 0 ? "t4_release" : "t4s_release", 4);
      in_valid = 1'b0;
      chk(pass == 0 ? "t4_writes" : "t4s_writes", 64'(wr_count - w0), 64'(1024));
    end

    // Reset in the middle of a load, then a fresh load from address 0.
    w0 = wr_count;
    do_start(5);
    beat(32'h5001, 10'd0, 1'b1);
    beat(32'h5002, 10'd1, 1'b1);
    reset = 1'b1; in_valid = 1'b1; in_data = 32'h99;
    @(negedge clk);
    chk("t5_after_reset", 64'({cpu_reset, busy, in_ready, imem_we}), 64'b1000);
    reset = 1'b0; in_valid = 1'b0;
    idle(3);
    chk("t5_partial_writes", 64'(wr_count - w0), 64'(2));
    do_start(2);
    beat(32'h6001, 10'd0, 1'b1);
    beat(32'h6002, 10'd1, 1'b1);
    wait_done("t5_reload_release", 4);

`ifdef BOOT_CHECKSUM_EN
    // Good trailer.
    w0 = wr_count;
    do_start(3);
    beat(32'd1, 10'd0, 1'b1);
    beat(32'd2, 10'd1, 1'b1);
    beat(32'd3, 10'd2, 1'b1);
    chk("c1_check_ready", 64'(in_ready), 64'(1));
    beat(32'd6, 10'd0, 1'b0);
    wait_done("c1_release", 4);
    chk("c1_writes", 64'(wr_count - w0), 64'(3));

    // Bad trailer parks in ERROR; a new start clears it.
    do_start(3);
    beat(32'd1, 10'd0, 1'b1);
    beat(32'd2, 10'd1, 1'b1);
    beat(32'd3, 10'd2, 1'b1);
    beat(32'd7, 10'd0, 1'b0);
    idle(6);
    chk("c2_error_flags", 64'({error, cpu_reset, done, busy}), 64'b1100);
    do_start(1);
    chk("c2_error_cleared", 64'({error, in_ready}), 64'b01);
    beat(32'h42, 10'd0, 1'b1);
    beat(32'h42, 10'd0, 1'b0);
    wait_done("c2_release", 4);
`else
    chk("no_checksum_error", 64'(error), 64'(0));
`endif

    idle(2);
    chk("scoreboard_drained", 64'(sb_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
